// File: rtl/wb_write_port_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
package wb_write_port_arbiter_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT    = 2'd1,
        ARB_STARVED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/wb_write_port_arbiter_fifo.sv
// Aux write buffer: DEPTH x W synchronous FIFO that also exposes its entries
// and a per-slot valid mask so the parent can search pending writes.
module wb_arb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 37
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [W-1:0]                 i_data,
    output logic [W-1:0]                 o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [DEPTH-1:0][W-1:0]      o_entries,
    output logic [DEPTH-1:0]             o_valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        o_entries = '0;
        o_valid   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_entries[i] = r_mem[i];
            o_valid[i]   = {1'b0, PTR_W'(i) - r_rd_ptr} < r_count;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_write_port_arbiter.sv
// Arbitrates the register-file write port between WB (always wins) and a buffered aux requester.
// Define WB_ARB_PENDING_EN to build the pending-write hazard compare on i_query_reg.
module wb_write_port_arbiter
    import wb_write_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned REG_W        = DEF_REG_W,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wb_reg_write,
    input  logic [REG_W-1:0]  i_wb_write_reg,
    input  logic [DATA_W-1:0] i_wb_write_data,
    input  logic              i_aux_valid,
    output logic              o_aux_ready,
    input  logic [REG_W-1:0]  i_aux_reg,
    input  logic [DATA_W-1:0] i_aux_data,
    output logic              o_reg_write,
    output logic [REG_W-1:0]  o_write_register,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_stall_req,
    input  logic [REG_W-1:0]  i_query_reg,
    output logic              o_pending_match
);

    localparam int unsigned ENT_W  = REG_W + DATA_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic                         w_wb_active;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_last_pop;
    logic                         w_full;
    logic                         w_empty;
    logic [CNT_W-1:0]             w_count;
    logic [ENT_W-1:0]             w_head;
    logic [DEPTH-1:0][ENT_W-1:0]  w_entries;
    logic [DEPTH-1:0]             w_valid;
    logic [WAIT_W-1:0]            r_wait;
    logic [WAIT_W-1:0]            w_wait_next;
    arb_state_t                   r_state;
    logic                         r_stall_req;

    assign w_wb_active = i_wb_reg_write && (i_wb_write_reg != REG_W'(REG_ZERO));
    assign w_pop       = !w_wb_active && !w_empty;
    assign w_push      = i_aux_valid && o_aux_ready && (i_aux_reg != REG_W'(REG_ZERO));
    assign w_last_pop  = w_pop && !w_push && (w_count == CNT_W'(1));
    assign o_aux_ready = !w_full;
    assign o_stall_req = r_stall_req;

    wb_arb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_data    ({i_aux_reg, i_aux_data}),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    // Write-port mux: WB pass-through, else drain the FIFO head.
    always_comb begin
        o_reg_write      = 1'b0;
        o_write_register = '0;
        o_write_data     = '0;
        if (w_wb_active) begin
            o_reg_write      = 1'b1;
            o_write_register = i_wb_write_reg;
            o_write_data     = i_wb_write_data;
        end else if (!w_empty) begin
            o_reg_write      = 1'b1;
            o_write_register = w_head[ENT_W-1 -: REG_W];
            o_write_data     = w_head[DATA_W-1:0];
        end
    end

    always_comb begin
        w_wait_next = r_wait;
        if (w_pop || w_empty) begin
            w_wait_next = '0;
        end else if (r_wait != WAIT_W'(STARVE_LIMIT)) begin
            w_wait_next = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_next;
        end
    end

    // Starvation FSM; stall request mirrors the STARVED state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_stall_req <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_push) begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (w_last_pop) begin
                        r_state <= ARB_IDLE;
                    end else if (w_wait_next == WAIT_W'(STARVE_LIMIT)) begin
                        r_state     <= ARB_STARVED;
                        r_stall_req <= 1'b1;
                    end
                end
                ARB_STARVED: begin
                    if (w_pop) begin
                        r_state     <= w_last_pop ? ARB_IDLE : ARB_WAIT;
                        r_stall_req <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_stall_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_PENDING_EN
    // Includes the head even when it is being popped this cycle.
    always_comb begin
        o_pending_match = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_entries[i][ENT_W-1 -: REG_W] == i_query_reg)
                && (i_query_reg != REG_W'(REG_ZERO))) begin
                o_pending_match = 1'b1;
            end
        end
    end
`else
    assign o_pending_match = 1'b0;
    logic w_unused;
    assign w_unused = ^{i_query_reg, w_entries, w_valid};
`endif

endmodule
